param_priority_arbiter: RTL and testbench
=========================================

Name: param_priority_arbiter

Overview:
- N-requester arbiter with a registered one-hot grant; the next generation of the team's 4-input fixed-priority arbiter.
- Adds run-time mode select (fixed priority or round-robin), sticky grants (owner keeps the grant while it holds req), and a MAX_HOLD tenure limit that forces the owner to yield to waiting requesters.
- Sits between N bus masters and a shared resource; also outputs the winner index for downstream muxing.

Parameters:
- N, 4, number of requesters (>=2).
- MAX_HOLD, 4, max consecutive cycles an owner keeps the grant while others wait (>=1).
- ID_W, $clog2(N), width of gnt_id (derived; not overridden).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = fixed priority (bit 0 highest), 1 = round-robin.
- req  input  N  per-requester request, level sensitive.
- gnt  output  N  registered one-hot grant, or all-zero.
- gnt_id  output  ID_W  binary index of the granted requester; 0 when gnt_valid=0.
- gnt_valid  output  1  high when gnt is non-zero.

Behaviour:
- Reset (asynchronous, immediate): gnt=0, gnt_id=0, gnt_valid=0, rr_ptr=0, hold_cnt=0. Holds while rst=1 regardless of req.
- Latency: outputs are registered. req sampled at edge k appears as gnt after edge k; no combinational req-to-gnt path.
- State: owner (gnt/gnt_id), hold_cnt (0..MAX_HOLD), rr_ptr (0..N-1).
- Decision at each edge, first matching rule wins:
  - a) req==0: gnt=0, gnt_valid=0, hold_cnt=0, rr_ptr unchanged.
  - b) owner valid, req[owner]=1, hold_cnt<MAX_HOLD: keep owner, hold_cnt++.
  - c) owner valid, req[owner]=1, hold_cnt==MAX_HOLD, no other req bit set: keep owner, hold_cnt=1 (new tenure, no yield).
  - d) owner valid, req[owner]=1, hold_cnt==MAX_HOLD, other requesters present: arbitrate over req with the owner bit masked out.
  - e) otherwise (no owner, or owner dropped req): arbitrate over full req.
- Arbitration:
  - Fixed mode: lowest set index wins.
  - RR mode: first set index searching upward from rr_ptr, wrapping N-1 to 0.
  - On every new grant to index i: hold_cnt=1, rr_ptr=(i+1) mod N. rr_ptr is updated in both modes.
- A fresh grant counts as cycle 1 of tenure. MAX_HOLD=1 therefore re-arbitrates every cycle whenever others wait.
- Mode change takes effect at the next arbitration decision; it never preempts an owner mid-tenure.
- Invariants: gnt is one-hot or zero; gnt[i]=1 only if req[i] was 1 at the granting edge; gnt_valid == |gnt; gnt_id == index(gnt).
- Starvation bound in RR mode: any continuously asserted req is granted within (N-1)*MAX_HOLD+1 cycles.
- Reset mid-tenure clears owner and rr_ptr; the first post-reset grant follows rule e) with rr_ptr=0.

Decomposition:
- Package arb_pkg:
  - constants ARB_MODE_FIXED=1'b0 and ARB_MODE_RR=1'b1.
  - clog2 helper returning a minimum of 1.
- Sub-module arb_prio_pick (combinational):
  - inputs: req_masked[N], base[ID_W].
  - outputs: found, idx[ID_W].
  - Rotated first-set search from base. Fixed mode passes base=0; RR mode passes base=rr_ptr.
- Top module holds owner/hold_cnt/rr_ptr registers and the rule a)-e) logic.

Test Plan (N=4, MAX_HOLD=4 unless stated):
- rst=1 with req=4'b1111 for 3 cycles -> gnt=0000, gnt_valid=0 throughout. Deassert rst -> first edge gives gnt=0001, gnt_id=0.
- Fixed mode, req held at 4'b1010 -> gnt=0010 for 4 cycles, then 1000 for 4 cycles, then 0010 for 4 cycles, repeating; gnt_id alternates 1/3.
- RR mode, req held at 4'b1111 -> gnt 0001x4, 0010x4, 0100x4, 1000x4, then 0001 again; rr_ptr wraps 3->0.
- Owner drop: owner=0010, req changes to 4'b1000 -> next edge gnt=1000, hold_cnt=1. Then req=0000 -> next edge gnt=0000, gnt_valid=0, rr_ptr stays 0.
- Sole requester, req=4'b0100 for 12 cycles in either mode -> gnt=0100 continuously with no gap; hold_cnt cycles 1..4.
- Async reset mid-tenure: owner=0100 with hold_cnt=2, pulse rst between edges -> gnt=0000 immediately (before next edge). After release with req=1111 in RR mode -> gnt=0001.
- MAX_HOLD=1, RR mode, req=4'b0011 -> gnt alternates 0001/0010 every cycle.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and helpers for the parameterised priority arbiter
//
// Purpose: arbitration mode encodings and a width helper used by the interface,
//          the picker and the top level.
// Ports:   none (package).

package arb_pkg;

  localparam logic ARB_MODE_FIXED = 1'b0;
  localparam logic ARB_MODE_RR    = 1'b1;

  // Bits needed to index n items, never less than 1 so a 1-bit field still exists.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/param_priority_arbiter_if.sv
// rtl/param_priority_arbiter_if.sv - request/grant bundle between masters and the arbiter
//
// Purpose: groups mode, request vector and grant outputs of the arbiter.
// Ports (signals):
//   mode      - 0 fixed priority, 1 round-robin (driven by the requester side)
//   req       - per-requester level request (driven by the requester side)
//   gnt       - registered one-hot grant (driven by the arbiter)
//   gnt_id    - binary index of the grant, 0 when idle (driven by the arbiter)
//   gnt_valid - grant present (driven by the arbiter)
// Modports: master = requester side, slave = arbiter side.

interface param_priority_arbiter_if
  import arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = clog2(N)
);

  logic            mode;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_valid;

  modport master (
    output mode,
    output req,
    input  gnt,
    input  gnt_id,
    input  gnt_valid
  );

  modport slave (
    input  mode,
    input  req,
    output gnt,
    output gnt_id,
    output gnt_valid
  );

endinterface

// File: rtl/arb_prio_pick.sv
// rtl/arb_prio_pick.sv - rotated first-set search over a request vector
//
// Purpose: finds the first set bit of req_masked_i starting at base_i and
//          wrapping from N-1 back to 0. base_i=0 gives plain lowest-index priority.
// Ports:
//   req_masked_i [N]    - candidate requests
//   base_i       [ID_W] - starting index of the search (must be < N)
//   found_o             - at least one candidate set
//   idx_o        [ID_W] - index of the winner, 0 when none found

module arb_prio_pick
  import arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = clog2(N)
) (
  input  logic [N-1:0]    req_masked_i,
  input  logic [ID_W-1:0] base_i,
  output logic            found_o,
  output logic [ID_W-1:0] idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = int'(base_i) + k;
      if (c >= N) c = c - N;
      if (!found_o && req_masked_i[c]) begin
        found_o = 1'b1;
        idx_o   = ID_W'(c);
      end
    end
  end

endmodule

// File: rtl/param_priority_arbiter.sv
// rtl/param_priority_arbiter.sv - N-way sticky arbiter with fixed/round-robin mode and tenure limit
//
// Purpose: registered one-hot grant among N requesters. The owner keeps the
//          grant while it requests, but after MAX_HOLD consecutive cycles it
//          yields if anyone else is waiting.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - slave side of param_priority_arbiter_if (mode, req in; gnt, gnt_id, gnt_valid out)

module param_priority_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  param_priority_arbiter_if.slave   bus
);

  localparam int ID_W   = clog2(N);
  localparam int HOLD_W = clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [ID_W-1:0]   LAST_ID  = ID_W'(N - 1);

  logic [N-1:0]      gnt_q,    gnt_d;
  logic [ID_W-1:0]   id_q,     id_d;
  logic              valid_q,  valid_d;
  logic [HOLD_W-1:0] hold_q,   hold_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [N-1:0]    others;
  logic            owner_req;
  logic [N-1:0]    pick_req;
  logic [ID_W-1:0] pick_base;
  logic            pick_found;
  logic [ID_W-1:0] pick_idx;

  // gnt_q is one-hot or zero, so the AND tells whether the owner still requests.
  assign owner_req = |(bus.req & gnt_q);
  assign others    = bus.req & ~gnt_q;

  // A yielding owner is excluded from the search; otherwise everyone competes.
  assign pick_req  = owner_req ? others : bus.req;
  assign pick_base = (bus.mode == ARB_MODE_RR) ? rr_ptr_q : '0;

  arb_prio_pick #(
    .N    (N),
    .ID_W (ID_W)
  ) u_pick (
    .req_masked_i (pick_req),
    .base_i       (pick_base),
    .found_o      (pick_found),
    .idx_o        (pick_idx)
  );

  always_comb begin
    gnt_d    = gnt_q;
    id_d     = id_q;
    valid_d  = valid_q;
    hold_d   = hold_q;
    rr_ptr_d = rr_ptr_q;

    if (bus.req == '0) begin
      gnt_d   = '0;
      id_d    = '0;
      valid_d = 1'b0;
      hold_d  = '0;
    end else if (owner_req && (hold_q < HOLD_MAX)) begin
      hold_d = hold_q + HOLD_ONE;
    end else if (owner_req && (others == '0)) begin
      // Tenure expired but nobody is waiting: start a fresh tenure, no gap.
      hold_d = HOLD_ONE;
    end else if (pick_found) begin
      gnt_d           = '0;
      gnt_d[pick_idx] = 1'b1;
      id_d            = pick_idx;
      valid_d         = 1'b1;
      hold_d          = HOLD_ONE;
      rr_ptr_d        = (pick_idx == LAST_ID) ? '0 : pick_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q    <= '0;
      id_q     <= '0;
      valid_q  <= 1'b0;
      hold_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      gnt_q    <= gnt_d;
      id_q     <= id_d;
      valid_q  <= valid_d;
      hold_q   <= hold_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = id_q;
  assign bus.gnt_valid = valid_q;

endmodule

// File: tb/tb_param_priority_arbiter.sv
// tb/tb_param_priority_arbiter.sv - self-checking bench for param_priority_arbiter

module tb_param_priority_arbiter;

  logic clk;
  logic rst;

  int vectors    = 0;
  int miscompares = 0;

  param_priority_arbiter_if #(.N(4)) bus4 ();
  param_priority_arbiter_if #(.N(4)) bus1 ();

  param_priority_arbiter #(.N(4), .MAX_HOLD(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  param_priority_arbiter #(.N(4), .MAX_HOLD(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model per DUT (0: MAX_HOLD=4, 1: MAX_HOLD=1); owner -1 = none.
  int m_owner [2];
  int m_hold  [2];
  int m_rr    [2];
  int m_max   [2];

  function automatic int first_from(input logic [3:0] r, input int base);
    for (int k = 0; k < 4; k++) begin
      if (r[(base + k) % 4]) return (base + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_owner[u] = -1;
      m_hold[u]  = 0;
      m_rr[u]    = 0;
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic md);
    for (int u = 0; u < 2; u++) begin
      logic [3:0] cand;
      int w;
      bit owner_wants;
      owner_wants = (m_owner[u] >= 0) && r[m_owner[u]];
      if (r == 4'b0000) begin
        m_owner[u] = -1;
        m_hold[u]  = 0;
      end else if (owner_wants && m_hold[u] < m_max[u]) begin
        m_hold[u]++;
      end else if (owner_wants && (r & ~(4'b0001 << m_owner[u])) == 4'b0000) begin
        m_hold[u] = 1;
      end else begin
        cand = owner_wants ? (r & ~(4'b0001 << m_owner[u])) : r;
        w = first_from(cand, md ? m_rr[u] : 0);
        m_owner[u] = w;
        m_hold[u]  = 1;
        m_rr[u]    = (w + 1) % 4;
      end
    end
  endtask

  function automatic logic [3:0] exp_gnt(input int u);
    return (m_owner[u] < 0) ? 4'b0000 : (4'b0001 << m_owner[u]);
  endfunction

  function automatic logic [1:0] exp_id(input int u);
    return (m_owner[u] < 0) ? 2'd0 : 2'(m_owner[u]);
  endfunction

  task automatic drive(input logic [3:0] r, input logic md);
    bus4.req = r;  bus4.mode = md;
    bus1.req = r;  bus1.mode = md;
  endtask

  // Advance one rising edge, update the model, and return 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_step(bus4.req, bus4.mode);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    drive(4'b1111, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (bus4.gnt !== 4'b0000 || bus4.gnt_valid !== 1'b0 || bus4.gnt_id !== 2'd0) begin
        miscompares++;
        $display("FAIL reset_hold cycle %0d: gnt=%b valid=%b id=%0d, want 0000/0/0", c, bus4.gnt, bus4.gnt_valid, bus4.gnt_id);
      end
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (bus4.gnt !== 4'b0001 || bus4.gnt_id !== 2'd0 || bus4.gnt_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: gnt=%b id=%0d valid=%b, want 0001/0/1", bus4.gnt, bus4.gnt_id, bus4.gnt_valid);
    end
  endtask

  task automatic test_fixed_alternate();
    logic [3:0] want;
    apply_reset();
    drive(4'b1010, 1'b0);
    for (int c = 0; c < 20; c++) begin
      tick();
      want = ((c / 4) % 2 == 0) ? 4'b0010 : 4'b1000;
      vectors++;
      if (bus4.gnt !== want || bus4.gnt_id !== ((want == 4'b0010) ? 2'd1 : 2'd3)) begin
        miscompares++;
        $display("FAIL fixed_alternate cycle %0d: gnt=%b id=%0d, want %b", c, bus4.gnt, bus4.gnt_id, want);
      end
    end
  endtask

  task automatic test_rr_rotate();
    int idx;
    apply_reset();
    drive(4'b1111, 1'b1);
    for (int c = 0; c < 20; c++) begin
      tick();
      idx = (c / 4) % 4;
      vectors++;
      if (bus4.gnt !== (4'b0001 << idx) || bus4.gnt_id !== 2'(idx)) begin
        miscompares++;
        $display("FAIL rr_rotate cycle %0d: gnt=%b id=%0d, want idx %0d", c, bus4.gnt, bus4.gnt_id, idx);
      end
    end
  endtask

  task automatic test_owner_drop();
    apply_reset();
    drive(4'b0010, 1'b0);
    tick();
    drive(4'b1000, 1'b0);
    tick();
    vectors++;
    if (bus4.gnt !== 4'b1000 || bus4.gnt_id !== 2'd3) begin
      miscompares++;
      $display("FAIL owner_drop_switch: gnt=%b id=%0d, want 1000/3", bus4.gnt, bus4.gnt_id);
    end
    drive(4'b0000, 1'b0);
    tick();
    vectors++;
    if (bus4.gnt !== 4'b0000 || bus4.gnt_valid !== 1'b0 || bus4.gnt_id !== 2'd0) begin
      miscompares++;
      $display("FAIL owner_drop_idle: gnt=%b valid=%b id=%0d, want 0000/0/0", bus4.gnt, bus4.gnt_valid, bus4.gnt_id);
    end
    // Grant index 1 (pointer -> 2), go idle, then RR over all must start at 2.
    drive(4'b0010, 1'b0);
    tick();
    drive(4'b0000, 1'b0);
    tick();
    drive(4'b1111, 1'b1);
    tick();
    vectors++;
    if (bus4.gnt !== 4'b0100) begin
      miscompares++;
      $display("FAIL idle_keeps_rr_ptr: gnt=%b, want 0100", bus4.gnt);
    end
  endtask

  task automatic test_sole_requester();
    for (int md = 0; md < 2; md++) begin
      apply_reset();
      drive(4'b0100, 1'(md));
      for (int c = 0; c < 12; c++) begin
        tick();
        vectors++;
        if (bus4.gnt !== 4'b0100 || bus1.gnt !== 4'b0100 || bus4.gnt_id !== 2'd2) begin
          miscompares++;
          $display("FAIL sole_requester mode %0d cycle %0d: gnt4=%b gnt1=%b id=%0d, want 0100", md, c, bus4.gnt, bus1.gnt, bus4.gnt_id);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(4'b0100, 1'b1);
    tick();
    tick();
    vectors++;
    if (bus4.gnt !== 4'b0100) begin
      miscompares++;
      $display("FAIL async_reset_setup: gnt=%b, want 0100", bus4.gnt);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (bus4.gnt !== 4'b0000 || bus4.gnt_valid !== 1'b0 || bus1.gnt !== 4'b0000) begin
      miscompares++;
      $display("FAIL async_reset_immediate: gnt4=%b valid=%b gnt1=%b, want 0000/0/0000", bus4.gnt, bus4.gnt_valid, bus1.gnt);
    end
    #2;
    rst = 1'b0;
    drive(4'b1111, 1'b1);
    tick();
    vectors++;
    if (bus4.gnt !== 4'b0001 || bus4.gnt_id !== 2'd0) begin
      miscompares++;
      $display("FAIL async_reset_first_grant: gnt=%b id=%0d, want 0001/0", bus4.gnt, bus4.gnt_id);
    end
  endtask

  task automatic test_max_hold_one();
    logic [3:0] want;
    apply_reset();
    drive(4'b0011, 1'b1);
    for (int c = 0; c < 10; c++) begin
      tick();
      want = (c % 2 == 0) ? 4'b0001 : 4'b0010;
      vectors++;
      if (bus1.gnt !== want) begin
        miscompares++;
        $display("FAIL max_hold_one cycle %0d: gnt=%b, want %b", c, bus1.gnt, want);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       md;
    apply_reset();
    md = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 15) == 0) md = ~md;
      case ($urandom_range(0, 9))
        0:       r = 4'b0000;
        1, 2, 3: r = bus4.req;
        default: r = 4'($urandom_range(0, 15));
      endcase
      drive(r, md);
      tick();
      for (int u = 0; u < 2; u++) begin
        logic [3:0] g;
        logic [1:0] id;
        logic       v;
        g  = (u == 0) ? bus4.gnt : bus1.gnt;
        id = (u == 0) ? bus4.gnt_id : bus1.gnt_id;
        v  = (u == 0) ? bus4.gnt_valid : bus1.gnt_valid;
        vectors++;
        if (g !== exp_gnt(u) || id !== exp_id(u) || v !== (m_owner[u] >= 0)) begin
          miscompares++;
          $display("FAIL random dut%0d cycle %0d req=%b mode=%b: gnt=%b id=%0d valid=%b, want %b/%0d/%0d",
                   u, c, r, md, g, id, v, exp_gnt(u), exp_id(u), (m_owner[u] >= 0));
        end
      end
    end
  endtask

  initial begin
    m_max[0] = 4;
    m_max[1] = 1;
    model_reset();
    rst = 1'b1;
    drive(4'b0000, 1'b0);
    test_reset();
    test_fixed_alternate();
    test_rr_rotate();
    test_owner_drop();
    test_sole_requester();
    test_async_reset();
    test_max_hold_one();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
